// File: rtl/cdb_pkg.sv
// cdb_pkg: shared CDB packet layout, idle encoding and source tagging.
package cdb_pkg;
  localparam logic [15:0] CDB_IDLE = 16'hFFFF;
  localparam int DEST_HI = 15;
  localparam int DEST_LO = 13;
  localparam int RS_HI = 12;
  localparam int RS_LO = 11;
  localparam int SRC_BIT = 10;
  localparam int DATA_HI = 9;
  localparam int DATA_LO = 0;
  typedef enum logic {SRC_LDSD = 1'b0, SRC_ULA = 1'b1} src_e;
  function automatic logic [15:0] tag_src(input logic [15:0] p, input src_e s);
    logic [15:0] r;
    r = p;
    r[SRC_BIT] = logic'(s);
    return r;
  endfunction
endpackage

// File: rtl/cdb_fifo.sv
// cdb_fifo: power-of-two packet FIFO; pointers carry an extra wrap bit for full/empty.
module cdb_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  assign empty_o = wr_q == rd_q;
  assign full_o = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign data_o = mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (pop_i) rd_q <= rd_q + (AW+1)'(1);
      if (push_i) begin
        mem_q[wr_q[AW-1:0]] <= data_i;
        wr_q <= wr_q + (AW+1)'(1);
      end
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: queues ALU and LD/SD results and broadcasts one per cycle on the CDB.
// Define CDB_FIXED_PRIORITY_EN to always favour the ALU queue instead of round-robin.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] ula_in,
  input  logic [15:0] ldsd_in,
  output logic [15:0] cdb,
  output logic        cdb_valid,
  output logic        ula_full,
  output logic        ldsd_full,
  output logic        overflow
);
`ifdef CDB_FIXED_PRIORITY_EN
  localparam bit FIXED_PRI = 1'b1;
`else
  localparam bit FIXED_PRI = 1'b0;
`endif
  logic [15:0] ula_prev_q, ldsd_prev_q, ula_head, ldsd_head, cdb_q, cdb_d;
  logic ula_new, ldsd_new, ula_push, ldsd_push, ula_pop, ldsd_pop, ula_empty, ldsd_empty;
  logic last_ula_q, valid_q, ovf_q;
  // producers hold their last value, so only a changed non-idle word is a new packet
  assign ula_new = (ula_in != CDB_IDLE) && (ula_in != ula_prev_q);
  assign ldsd_new = (ldsd_in != CDB_IDLE) && (ldsd_in != ldsd_prev_q);
  assign ula_pop = !ula_empty && (FIXED_PRI || ldsd_empty || !last_ula_q);
  assign ldsd_pop = !ldsd_empty && !ula_pop;
  assign ula_push = ula_new && (!ula_full || ula_pop);
  assign ldsd_push = ldsd_new && (!ldsd_full || ldsd_pop);
  assign cdb_d = ula_pop ? tag_src(ula_head, SRC_ULA) : ldsd_pop ? tag_src(ldsd_head, SRC_LDSD) : CDB_IDLE;
  cdb_fifo #(.DEPTH(DEPTH), .W(16)) u_ula_fifo (
    .clk_i(clock), .rst_i(reset), .push_i(ula_push), .pop_i(ula_pop),
    .data_i(ula_in), .data_o(ula_head), .full_o(ula_full), .empty_o(ula_empty)
  );
  cdb_fifo #(.DEPTH(DEPTH), .W(16)) u_ldsd_fifo (
    .clk_i(clock), .rst_i(reset), .push_i(ldsd_push), .pop_i(ldsd_pop),
    .data_i(ldsd_in), .data_o(ldsd_head), .full_o(ldsd_full), .empty_o(ldsd_empty)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      ula_prev_q <= CDB_IDLE;
      ldsd_prev_q <= CDB_IDLE;
      cdb_q <= CDB_IDLE;
      valid_q <= 1'b0;
      last_ula_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      ula_prev_q <= ula_in;
      ldsd_prev_q <= ldsd_in;
      cdb_q <= cdb_d;
      valid_q <= ula_pop || ldsd_pop;
      if (ula_pop || ldsd_pop) last_ula_q <= ula_pop;
      ovf_q <= ovf_q || (ula_new && !ula_push) || (ldsd_new && !ldsd_push);
    end
  end
  assign cdb = cdb_q;
  assign cdb_valid = valid_q;
  assign overflow = ovf_q;
endmodule
